// File: rtl/shift_unit_ctrl_if.sv
// Request/response handshake plus the shared barrel-shifter port of shift_unit_ctrl.
// The slave modport is the controller; the master modport is its environment.
interface shift_unit_ctrl_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  op_i;
  logic [31:0] data_i;
  logic [4:0]  shamt_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic [31:0] sh_in_o;
  logic [4:0]  sh_cntrl_o;
  logic [31:0] sh_out_i;

  modport slave (
    input  in_valid_i, op_i, data_i, shamt_i, out_ready_i, sh_out_i,
    output in_ready_o, out_valid_o, result_o, sh_in_o, sh_cntrl_o
  );

  modport master (
    output in_valid_i, op_i, data_i, shamt_i, out_ready_i, sh_out_i,
    input  in_ready_o, out_valid_o, result_o, sh_in_o, sh_cntrl_o
  );
endinterface

// File: rtl/shift_unit_ctrl.sv
// Sequences SLL/SRL/SRA over a shared 32-bit left barrel shifter.
// Define SHIFT_UNIT_CTRL_SRA_EN to enable sign fill for SRA (adds the MASK pass).
module shift_unit_ctrl #(
  parameter bit ZERO_SHAMT_BYPASS = 1'b1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  shift_unit_ctrl_if.slave bus
);

  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
`ifdef SHIFT_UNIT_CTRL_SRA_EN
    StMask  = 2'd2,
`endif
    StDone  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [31:0] result_q, result_d;
  logic [31:0] sh_in;
  logic [4:0]  sh_cntrl;
  logic        is_right;

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Right shifts run on the left shifter by reversing bits on the way in and out.
  assign is_right = (op_q == OpSrl) || (op_q == OpSra);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    shamt_d  = shamt_q;
    result_d = result_q;
    sh_in    = '0;
    sh_cntrl = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid_i) begin
          op_d    = bus.op_i;
          data_d  = bus.data_i;
          shamt_d = bus.shamt_i;
          if (ZERO_SHAMT_BYPASS && (bus.shamt_i == 5'd0)) begin
            result_d = bus.data_i;
            state_d  = StDone;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        sh_in    = is_right ? bit_rev(data_q) : data_q;
        sh_cntrl = shamt_q;
        result_d = is_right ? bit_rev(bus.sh_out_i) : bus.sh_out_i;
        state_d  = StDone;
`ifdef SHIFT_UNIT_CTRL_SRA_EN
        if ((op_q == OpSra) && data_q[31]) state_d = StMask;
`endif
      end
`ifdef SHIFT_UNIT_CTRL_SRA_EN
      StMask: begin
        // Ones shifted by shamt, reversed and inverted, give the sign-fill mask.
        sh_in    = '1;
        sh_cntrl = shamt_q;
        result_d = result_q | ~bit_rev(bus.sh_out_i);
        state_d  = StDone;
      end
`endif
      StDone: begin
        if (bus.out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      op_q     <= '0;
      data_q   <= '0;
      shamt_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      shamt_q  <= shamt_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready_o  = (state_q == StIdle);
  assign bus.out_valid_o = (state_q == StDone);
  assign bus.result_o    = result_q;
  assign bus.sh_in_o     = sh_in;
  assign bus.sh_cntrl_o  = sh_cntrl;

endmodule

// File: tb/tb_shift_unit_ctrl.sv
// Directed bench for shift_unit_ctrl; models the shared left barrel shifter.
module tb_shift_unit_ctrl;

`ifdef SHIFT_UNIT_CTRL_SRA_EN
  localparam logic [31:0] SraNegRes = 32'hF800_0000;
  localparam int          SraNegLat = 3;
`else
  localparam logic [31:0] SraNegRes = 32'h0800_0000;
  localparam int          SraNegLat = 2;
`endif

  logic clk = 1'b0;
  logic rstn;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  shift_unit_ctrl_if bus ();

  assign bus.sh_out_i = bus.sh_in_o << bus.sh_cntrl_o;

  shift_unit_ctrl #(
    .ZERO_SHAMT_BYPASS(1'b1)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] op, input logic [31:0] data, input logic [4:0] shamt);
    bus.op_i       = op;
    bus.data_i     = data;
    bus.shamt_i    = shamt;
    bus.in_valid_i = 1'b1;
    check("in_ready before handshake", 32'(bus.in_ready_o), 32'd1);
    tick();
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.out_valid_o !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain(input string tag, input logic [31:0] exp);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    check({tag, " out_valid after drain"}, 32'(bus.out_valid_o), 32'd0);
    check({tag, " in_ready after drain"}, 32'(bus.in_ready_o), 32'd1);
    tick();
    check({tag, " result held in idle"}, bus.result_o, exp);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] data,
                     input logic [4:0] shamt, input logic [31:0] exp, input int exp_lat);
    int lat;
    start(op, data, shamt);
    wait_done(lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, bus.result_o, exp);
    drain(tag, exp);
  endtask

  initial begin
    int  lat;
    logic seen_valid;
    rstn            = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.op_i        = 2'b00;
    bus.data_i      = '0;
    bus.shamt_i     = '0;
    bus.out_ready_i = 1'b0;
    repeat (2) tick();
    check("reset in_ready", 32'(bus.in_ready_o), 32'd1);
    check("reset out_valid", 32'(bus.out_valid_o), 32'd0);
    check("reset result", bus.result_o, 32'h0);
    check("reset sh_in", bus.sh_in_o, 32'h0);
    check("reset sh_cntrl", 32'(bus.sh_cntrl_o), 32'd0);
    rstn = 1'b1;
    tick();

    // SLL 1 << 31, shifter driven with data and shamt during SHIFT
    start(2'b00, 32'h0000_0001, 5'd31);
    check("sll31 sh_cntrl", 32'(bus.sh_cntrl_o), 32'd31);
    check("sll31 sh_in", bus.sh_in_o, 32'h0000_0001);
    wait_done(lat);
    check("sll31 latency", 32'(lat), 32'd2);
    check("sll31 result", bus.result_o, 32'h8000_0000);
    check("done sh_in", bus.sh_in_o, 32'h0);
    drain("sll31", 32'h8000_0000);

    // SRL feeds the reversed operand to the shifter
    start(2'b01, 32'h8000_0000, 5'd4);
    check("srl sh_in reversed", bus.sh_in_o, 32'h0000_0001);
    wait_done(lat);
    check("srl latency", 32'(lat), 32'd2);
    check("srl result", bus.result_o, 32'h0800_0000);
    drain("srl", 32'h0800_0000);

    run("sra_neg", 2'b10, 32'h8000_0000, 5'd4, SraNegRes, SraNegLat);
    run("sra_pos", 2'b10, 32'h7FFF_FFF0, 5'd4, 32'h07FF_FFFF, 2);
    run("op11_as_sll", 2'b11, 32'h0000_0003, 5'd2, 32'h0000_000C, 2);

    // Zero shamt bypass never touches the shifter
    start(2'b00, 32'h1234_5678, 5'd0);
    check("bypass sh_in", bus.sh_in_o, 32'h0);
    wait_done(lat);
    check("bypass latency", 32'(lat), 32'd1);
    check("bypass result", bus.result_o, 32'h1234_5678);
    drain("bypass", 32'h1234_5678);

    // Backpressure in DONE with a competing request held valid
    start(2'b01, 32'h0000_00F0, 5'd4);
    wait_done(lat);
    check("stall latency", 32'(lat), 32'd2);
    bus.op_i       = 2'b00;
    bus.data_i     = 32'h0000_AAAA;
    bus.shamt_i    = 5'd1;
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall out_valid", 32'(bus.out_valid_o), 32'd1);
      check("stall result", bus.result_o, 32'h0000_000F);
      check("stall in_ready", 32'(bus.in_ready_o), 32'd0);
      tick();
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    check("stall drained out_valid", 32'(bus.out_valid_o), 32'd0);
    check("stall drained in_ready", 32'(bus.in_ready_o), 32'd1);
    check("stall drained result", bus.result_o, 32'h0000_000F);
    tick();

    // Reset mid-operation discards it
    start(2'b10, 32'h8000_0000, 5'd4);
`ifdef SHIFT_UNIT_CTRL_SRA_EN
    tick();
    check("mask sh_in", bus.sh_in_o, 32'hFFFF_FFFF);
`endif
    rstn = 1'b0;
    #1;
    check("midreset out_valid", 32'(bus.out_valid_o), 32'd0);
    check("midreset result", bus.result_o, 32'h0);
    check("midreset sh_in", bus.sh_in_o, 32'h0);
    check("midreset sh_cntrl", 32'(bus.sh_cntrl_o), 32'd0);
    check("midreset in_ready", 32'(bus.in_ready_o), 32'd1);
    tick();
    rstn = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid_o !== 1'b0) seen_valid = 1'b1;
      tick();
    end
    check("midreset no result", 32'(seen_valid), 32'd0);
    run("post_reset_sll", 2'b00, 32'h0000_0001, 5'd1, 32'h0000_0002, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_unit_ctrl.md
SHIFT_UNIT_CTRL -- requirements
Module: shift_unit_ctrl

Interface
REQ-001 Parameter: ZERO_SHAMT_BYPASS, default 1, meaning: when 1, a shamt of 0 skips the shifter and completes in 1 cycle.
REQ-002 clk_i  input  1  Single clock; all state updates on rising edge.
REQ-003 rstn_i  input  1  Reset, asynchronous and active-low.
REQ-004 in_valid_i  input  1  Request valid.
REQ-005 in_ready_o  output  1  Controller can accept a request.
REQ-006 op_i  input  2  Operation: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-007 data_i  input  32  Operand.
REQ-008 shamt_i  input  5  Shift amount.
REQ-009 out_valid_o  output  1  Result valid.
REQ-010 out_ready_i  input  1  Consumer accepts the result.
REQ-011 result_o  output  32  Shift result.
REQ-012 sh_in_o  output  32  Drives the in port of the shared 32-bit left barrel shifter.
REQ-013 sh_cntrl_o  output  5  Drives the cntrl port of the shifter.
REQ-014 sh_out_i  input  32  Combinational out port of the shifter, valid in the same cycle.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, MASK and DONE; in_ready_o SHALL be 1 only in IDLE and SHALL be decoded from registered state only.
REQ-016 A handshake (in_valid_i and in_ready_o) SHALL register op, data and shamt, and SHALL move to SHIFT, or to DONE with result_o=data_i when ZERO_SHAMT_BYPASS=1 and shamt_i=0.
REQ-017 In SHIFT: sh_in_o SHALL be data for SLL and bit-reversed data for SRL/SRA; sh_cntrl_o SHALL be shamt; the partial result register SHALL capture sh_out_i for SLL and bit-reversed sh_out_i for SRL/SRA.
REQ-018 From SHIFT the FSM SHALL go to MASK for SRA with data[31]=1, otherwise to DONE with result_o equal to the partial result.
REQ-019 In MASK: sh_in_o SHALL be 0xFFFFFFFF and sh_cntrl_o SHALL be shamt; result_o SHALL become partial OR NOT(bit-reverse(sh_out_i)); the FSM SHALL then go to DONE.
REQ-020 In IDLE and DONE, sh_in_o and sh_cntrl_o SHALL be 0.
REQ-021 out_valid_o SHALL be 1 exactly in DONE; result_o SHALL stay stable until out_valid_o and out_ready_i are both 1, after which the FSM SHALL return to IDLE.
REQ-022 Latency from the handshake edge to out_valid_o: 1 cycle for bypass, 2 cycles for SLL/SRL/SRA-positive, 3 cycles for SRA-negative.
REQ-023 No new request SHALL be accepted in DONE, even in the cycle the result drains; back-to-back throughput SHALL be at most one operation per (latency+1) cycles.
REQ-024 Reserved op 11 SHALL execute as SLL.
REQ-025 result_o SHALL hold its last value in IDLE.

Reset
REQ-026 Asserting rstn_i low SHALL immediately force IDLE, in_ready_o=1 after release, out_valid_o=0, result_o=0, sh_in_o=0, sh_cntrl_o=0, and clear all captured operands.
REQ-027 Reset asserted in SHIFT, MASK or DONE SHALL discard the in-flight operation with no result delivered.

Configuration
REQ-028 Macro SHIFT_UNIT_CTRL_SRA_EN: when defined, REQ-018/019 apply; when undefined, the MASK state SHALL NOT exist and op 10 SHALL execute exactly as SRL (zero fill, 2-cycle latency).

Verification
REQ-029 SLL data=0x00000001 shamt=31 -> result 0x80000000, out_valid_o 2 cycles after handshake, sh_cntrl_o=31 in SHIFT.
REQ-030 SRL data=0x80000000 shamt=4 -> result 0x08000000, latency 2; SRA same operands -> 0xF8000000, latency 3 (with macro), or 0x08000000, latency 2 (without macro).
REQ-031 SRA data=0x7FFFFFF0 shamt=4 -> 0x07FFFFFF, latency 2, MASK state never entered.
REQ-032 ZERO_SHAMT_BYPASS=1, SLL data=0x12345678 shamt=0 -> result 0x12345678 after 1 cycle, sh_in_o stays 0 throughout.
REQ-033 out_ready_i held low 5 cycles in DONE -> out_valid_o=1 and result_o constant, in_ready_o=0 with in_valid_i=1 asserted, then one transfer and return to IDLE.
REQ-034 rstn_i pulsed low in MASK during SRA 0x80000000>>4 -> out_valid_o never asserts, all outputs 0, next request SLL 0x1<<1 returns 0x00000002.
